// File: rtl/deinterleave_sched_if.sv
// Bundle of the demodulator/deinterleaver handshake signals around the
// per-symbol sequencer. The slave modport is the sequencer itself.
interface deinterleave_sched_if #(
  parameter int unsigned SYM_W = 16
) ();
  logic             enable;
  logic [7:0]       rate_in;
  logic             rate_valid;
  logic [5:0]       in_bits;
  logic             in_strobe;
  logic             in_ready;
  logic [7:0]       deint_rate;
  logic [5:0]       deint_bits;
  logic             deint_strobe;
  logic             deint_out_strobe;
  logic             symbol_done;
  logic [SYM_W-1:0] sym_count;
  logic             err_overrun;
  logic             err_rate;
  logic             err_timeout;

  modport slave (
    input  enable, rate_in, rate_valid, in_bits, in_strobe, deint_out_strobe,
    output in_ready, deint_rate, deint_bits, deint_strobe, symbol_done, sym_count,
           err_overrun, err_rate, err_timeout
  );

  modport master (
    output enable, rate_in, rate_valid, in_bits, in_strobe, deint_out_strobe,
    input  in_ready, deint_rate, deint_bits, deint_strobe, symbol_done, sym_count,
           err_overrun, err_rate, err_timeout
  );
endinterface

// File: rtl/deinterleave_sched.sv
// Per-symbol sequencer for the OFDM deinterleaver: admits one symbol of
// carriers, back-pressures the demodulator while the deinterleaver drains,
// keeps the rate fixed per symbol and reports overrun/bad-rate/stall events.
module deinterleave_sched #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned SYM_W   = 16
) (
  input logic                clock,
  input logic                reset,
  deinterleave_sched_if.slave io_bus
);

  localparam int unsigned StallW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  // Legacy codes are the eight with bit3 set; HT needs MCS 0..7 only.
  function automatic logic f_rate_ok(input logic [7:0] rate);
    if (rate[7]) begin
      return rate[6:3] == 4'd0;
    end
    return rate[3];
  endfunction

  function automatic logic [8:0] f_ndbps(input logic [7:0] rate);
    logic [8:0] n;
    n = 9'd0;
    if (rate[7]) begin
      case (rate[2:0])
        3'd0:    n = 9'd26;
        3'd1:    n = 9'd52;
        3'd2:    n = 9'd78;
        3'd3:    n = 9'd104;
        3'd4:    n = 9'd156;
        3'd5:    n = 9'd208;
        3'd6:    n = 9'd234;
        default: n = 9'd260;
      endcase
    end else begin
      case (rate[3:0])
        4'b1011: n = 9'd24;
        4'b1111: n = 9'd36;
        4'b1010: n = 9'd48;
        4'b1110: n = 9'd72;
        4'b1001: n = 9'd96;
        4'b1101: n = 9'd144;
        4'b1000: n = 9'd192;
        4'b1100: n = 9'd216;
        default: n = 9'd0;
      endcase
    end
    return n;
  endfunction

  state_e           r_state, w_state_nxt;
  logic [7:0]       r_deint_rate, w_deint_rate_nxt;
  logic             r_rate_ok, w_rate_ok_nxt;
  logic             r_pend_valid, w_pend_valid_nxt;
  logic [7:0]       r_pend_rate, w_pend_rate_nxt;
  logic [5:0]       r_car_cnt, w_car_cnt_nxt;
  logic [8:0]       r_pair_cnt, w_pair_cnt_nxt;
  logic [StallW-1:0] r_stall_cnt, w_stall_cnt_nxt;
  logic [SYM_W-1:0] r_sym_count, w_sym_count_nxt;
  logic             r_err_overrun, w_err_overrun_nxt;
  logic             r_err_rate, w_err_rate_nxt;
  logic             r_err_timeout, w_err_timeout_nxt;

  logic       w_idle;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_rate_hit;
  logic [7:0] w_eff_rate;
  logic [5:0] w_nsc;
  logic [8:0] w_ndbps;

  // Handshake decode and the rate the deinterleaver sees this cycle.
  always_comb begin
    w_idle     = (r_state == StIdle);
    w_in_ready = io_bus.enable && ((r_state == StLoad) || (w_idle && r_rate_ok));
    w_accept   = io_bus.enable && io_bus.in_strobe && w_in_ready;
    w_rate_hit = io_bus.enable && io_bus.rate_valid && f_rate_ok(io_bus.rate_in);
    w_nsc      = r_deint_rate[7] ? 6'd52 : 6'd48;
    w_ndbps    = f_ndbps(r_deint_rate);
    // In IDLE a fresh or pending rate is bypassed so a carrier accepted in the
    // same cycle already belongs to the new rate.
    w_eff_rate = r_deint_rate;
    if (w_idle && w_rate_hit) begin
      w_eff_rate = io_bus.rate_in;
    end else if (w_idle && io_bus.enable && r_pend_valid) begin
      w_eff_rate = r_pend_rate;
    end
  end

  // Next-state logic: everything holds while enable is low.
  always_comb begin
    w_state_nxt       = r_state;
    w_deint_rate_nxt  = r_deint_rate;
    w_rate_ok_nxt     = r_rate_ok;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_rate_nxt   = r_pend_rate;
    w_car_cnt_nxt     = r_car_cnt;
    w_pair_cnt_nxt    = r_pair_cnt;
    w_stall_cnt_nxt   = r_stall_cnt;
    w_sym_count_nxt   = r_sym_count;
    w_err_overrun_nxt = 1'b0;
    w_err_rate_nxt    = 1'b0;
    w_err_timeout_nxt = 1'b0;
    if (io_bus.enable) begin
      w_err_rate_nxt    = io_bus.rate_valid && !f_rate_ok(io_bus.rate_in);
      w_err_overrun_nxt = io_bus.in_strobe && !w_in_ready;
      if (w_rate_hit) begin
        w_rate_ok_nxt = 1'b1;
      end
      if (w_idle) begin
        w_deint_rate_nxt = w_eff_rate;
        w_pend_valid_nxt = 1'b0;
      end else if (w_rate_hit) begin
        w_pend_valid_nxt = 1'b1;
        w_pend_rate_nxt  = io_bus.rate_in;
      end
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            w_state_nxt   = StLoad;
            w_car_cnt_nxt = 6'd1;
          end
        end
        StLoad: begin
          if (w_accept) begin
            if (r_car_cnt == w_nsc - 6'd1) begin
              w_state_nxt     = StDrain;
              w_pair_cnt_nxt  = 9'd0;
              w_stall_cnt_nxt = '0;
            end else begin
              w_car_cnt_nxt = r_car_cnt + 6'd1;
            end
          end
        end
        StDrain: begin
          if (io_bus.deint_out_strobe) begin
            w_stall_cnt_nxt = '0;
            if (r_pair_cnt == w_ndbps - 9'd1) begin
              w_state_nxt = StDone;
            end else begin
              w_pair_cnt_nxt = r_pair_cnt + 9'd1;
            end
          end else if (r_stall_cnt == StallW'(TIMEOUT - 1)) begin
            w_state_nxt       = StIdle;
            w_err_timeout_nxt = 1'b1;
          end else begin
            w_stall_cnt_nxt = r_stall_cnt + 1'b1;
          end
        end
        default: begin
          w_sym_count_nxt = r_sym_count + 1'b1;
          w_state_nxt     = StIdle;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= StIdle;
      r_deint_rate  <= 8'd0;
      r_rate_ok     <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_rate   <= 8'd0;
      r_car_cnt     <= 6'd0;
      r_pair_cnt    <= 9'd0;
      r_stall_cnt   <= '0;
      r_sym_count   <= '0;
      r_err_overrun <= 1'b0;
      r_err_rate    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_deint_rate  <= w_deint_rate_nxt;
      r_rate_ok     <= w_rate_ok_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_rate   <= w_pend_rate_nxt;
      r_car_cnt     <= w_car_cnt_nxt;
      r_pair_cnt    <= w_pair_cnt_nxt;
      r_stall_cnt   <= w_stall_cnt_nxt;
      r_sym_count   <= w_sym_count_nxt;
      r_err_overrun <= w_err_overrun_nxt;
      r_err_rate    <= w_err_rate_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end

  // Output drive.
  always_comb begin
    io_bus.in_ready     = w_in_ready;
    io_bus.deint_rate   = w_eff_rate;
    io_bus.deint_bits   = io_bus.in_bits;
    io_bus.deint_strobe = w_accept;
    io_bus.symbol_done  = io_bus.enable && (r_state == StDone);
    io_bus.sym_count    = r_sym_count;
    io_bus.err_overrun  = r_err_overrun;
    io_bus.err_rate     = r_err_rate;
    io_bus.err_timeout  = r_err_timeout;
  end

endmodule

// File: tb/tb_deinterleave_sched.sv
// Directed bench for deinterleave_sched: one task per scenario.
module tb_deinterleave_sched;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  deinterleave_sched_if #(.SYM_W(16)) bus ();

  deinterleave_sched #(.TIMEOUT(255), .SYM_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .io_bus(bus)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rate(input logic [7:0] r);
    bus.rate_in    = r;
    bus.rate_valid = 1'b1;
    cyc();
    bus.rate_valid = 1'b0;
  endtask

  task automatic send_carriers(input int n, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      bus.in_strobe = 1'b1;
      bus.in_bits   = 6'(i);
      #1;
      if (bus.deint_strobe) acc++;
      cyc();
    end
    bus.in_strobe = 1'b0;
  endtask

  // Drives n back-to-back pairs; returns how many cycles showed symbol_done.
  task automatic send_pairs(input int n, output int early);
    early = 0;
    for (int i = 0; i < n; i++) begin
      bus.deint_out_strobe = 1'b1;
      #1;
      if (bus.symbol_done) early++;
      cyc();
    end
    bus.deint_out_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.deint_rate !== 8'd0 || bus.sym_count !== 16'd0 ||
        bus.symbol_done !== 1'b0 || bus.err_overrun !== 1'b0 || bus.err_rate !== 1'b0 ||
        bus.err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b rate=%h cnt=%0d done=%b ov=%b er=%b to=%b want all 0",
               bus.in_ready, bus.deint_rate, bus.sym_count, bus.symbol_done,
               bus.err_overrun, bus.err_rate, bus.err_timeout);
    end
  endtask

  task automatic test_legacy();
    int acc, early;
    set_rate(8'h0B);
    checks++;
    if (bus.deint_rate !== 8'h0B || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL legacy_rate: rate=%h rdy=%b want 0b 1", bus.deint_rate, bus.in_ready);
    end
    bus.in_bits = 6'h2A;
    #1;
    checks++;
    if (bus.deint_bits !== 6'h2A || bus.deint_strobe !== 1'b0) begin
      errors++;
      $display("FAIL bits_pass: bits=%h stb=%b want 2a 0", bus.deint_bits, bus.deint_strobe);
    end
    send_carriers(48, acc);
    checks++;
    if (acc !== 48 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL legacy_load: acc=%0d rdy=%b want 48 0", acc, bus.in_ready);
    end
    send_pairs(23, early);
    checks++;
    if (early !== 0 || bus.symbol_done !== 1'b0) begin
      errors++;
      $display("FAIL legacy_early: early=%0d done=%b want 0 0", early, bus.symbol_done);
    end
    send_pairs(1, early);
    checks++;
    if (bus.symbol_done !== 1'b1 || bus.sym_count !== 16'd0) begin
      errors++;
      $display("FAIL legacy_done: done=%b cnt=%0d want 1 0", bus.symbol_done, bus.sym_count);
    end
    cyc();
    checks++;
    if (bus.symbol_done !== 1'b0 || bus.sym_count !== 16'd1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL legacy_idle: done=%b cnt=%0d rdy=%b want 0 1 1",
               bus.symbol_done, bus.sym_count, bus.in_ready);
    end
  endtask

  task automatic test_ht_overrun();
    int acc, early;
    set_rate(8'h87);
    send_carriers(53, acc);
    checks++;
    if (acc !== 52 || bus.err_overrun !== 1'b1 || bus.deint_rate !== 8'h87) begin
      errors++;
      $display("FAIL ht_load: acc=%0d ov=%b rate=%h want 52 1 87",
               acc, bus.err_overrun, bus.deint_rate);
    end
    cyc();
    checks++;
    if (bus.err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ht_ov_pulse: ov=%b want 0", bus.err_overrun);
    end
    send_pairs(260, early);
    checks++;
    if (early !== 0 || bus.symbol_done !== 1'b1) begin
      errors++;
      $display("FAIL ht_done: early=%0d done=%b want 0 1", early, bus.symbol_done);
    end
    cyc();
    checks++;
    if (bus.sym_count !== 16'd2) begin
      errors++;
      $display("FAIL ht_count: cnt=%0d want 2", bus.sym_count);
    end
  endtask

  task automatic test_rate_change();
    int acc, acc2, early;
    set_rate(8'h0B);
    send_carriers(10, acc);
    bus.rate_in    = 8'h0C;
    bus.rate_valid = 1'b1;
    send_carriers(1, acc2);
    bus.rate_valid = 1'b0;
    acc = acc + acc2;
    send_carriers(37, acc2);
    acc = acc + acc2;
    checks++;
    if (acc !== 48 || bus.deint_rate !== 8'h0B || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rc_load: acc=%0d rate=%h rdy=%b want 48 0b 0",
               acc, bus.deint_rate, bus.in_ready);
    end
    send_pairs(23, early);
    checks++;
    if (bus.symbol_done !== 1'b0) begin
      errors++;
      $display("FAIL rc_first_early: done=%b want 0", bus.symbol_done);
    end
    send_pairs(1, early);
    checks++;
    if (bus.symbol_done !== 1'b1) begin
      errors++;
      $display("FAIL rc_first_done: done=%b want 1", bus.symbol_done);
    end
    cyc();
    checks++;
    if (bus.deint_rate !== 8'h0C) begin
      errors++;
      $display("FAIL rc_new_rate: rate=%h want 0c", bus.deint_rate);
    end
    send_carriers(48, acc);
    send_pairs(215, early);
    checks++;
    if (acc !== 48 || early !== 0 || bus.symbol_done !== 1'b0) begin
      errors++;
      $display("FAIL rc_second_early: acc=%0d early=%0d done=%b want 48 0 0",
               acc, early, bus.symbol_done);
    end
    send_pairs(1, early);
    checks++;
    if (bus.symbol_done !== 1'b1) begin
      errors++;
      $display("FAIL rc_second_done: done=%b want 1", bus.symbol_done);
    end
    cyc();
    checks++;
    if (bus.sym_count !== 16'd4) begin
      errors++;
      $display("FAIL rc_count: cnt=%0d want 4", bus.sym_count);
    end
  endtask

  task automatic test_bad_rate();
    int acc;
    do_reset();
    set_rate(8'h05);
    checks++;
    if (bus.err_rate !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bad_legacy: er=%b rdy=%b want 1 0", bus.err_rate, bus.in_ready);
    end
    cyc();
    checks++;
    if (bus.err_rate !== 1'b0) begin
      errors++;
      $display("FAIL bad_pulse: er=%b want 0", bus.err_rate);
    end
    set_rate(8'h88);
    checks++;
    if (bus.err_rate !== 1'b1 || bus.deint_rate !== 8'd0) begin
      errors++;
      $display("FAIL bad_ht: er=%b rate=%h want 1 00", bus.err_rate, bus.deint_rate);
    end
    send_carriers(5, acc);
    checks++;
    if (acc !== 0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bad_blocked: acc=%0d rdy=%b want 0 0", acc, bus.in_ready);
    end
  endtask

  task automatic test_timeout();
    int acc, early, n;
    bit seen;
    set_rate(8'h0B);
    send_carriers(48, acc);
    send_pairs(10, early);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      cyc();
      n++;
      if (bus.err_timeout) seen = 1'b1;
    end
    checks++;
    if (!seen || n !== 255) begin
      errors++;
      $display("FAIL timeout_delay: seen=%b cycles=%0d want 1 255", seen, n);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.sym_count !== 16'd0 || bus.symbol_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: rdy=%b cnt=%0d done=%b want 1 0 0",
               bus.in_ready, bus.sym_count, bus.symbol_done);
    end
    cyc();
    checks++;
    if (bus.err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: to=%b want 0", bus.err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    int acc, early;
    send_carriers(30, acc);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.deint_rate !== 8'd0 || bus.sym_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b rate=%h cnt=%0d want 0 00 0",
               bus.in_ready, bus.deint_rate, bus.sym_count);
    end
    set_rate(8'h0B);
    send_carriers(48, acc);
    checks++;
    if (acc !== 48 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_fresh: acc=%0d rdy=%b want 48 0", acc, bus.in_ready);
    end
    send_pairs(24, early);
    cyc();
    checks++;
    if (bus.sym_count !== 16'd1) begin
      errors++;
      $display("FAIL reset_sym: cnt=%0d want 1", bus.sym_count);
    end
  endtask

  task automatic test_enable_freeze();
    int acc, early, bad;
    send_carriers(48, acc);
    send_pairs(10, early);
    bad = 0;
    bus.enable           = 1'b0;
    bus.deint_out_strobe = 1'b1;
    bus.in_strobe        = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.deint_strobe || bus.in_ready || bus.symbol_done || bus.err_overrun) bad++;
      cyc();
    end
    bus.enable    = 1'b1;
    bus.in_strobe = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL freeze_outputs: active_cycles=%0d want 0", bad);
    end
    send_pairs(13, early);
    checks++;
    if (early !== 0 || bus.symbol_done !== 1'b0 || bus.err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL freeze_early: early=%0d done=%b ov=%b want 0 0 0",
               early, bus.symbol_done, bus.err_overrun);
    end
    send_pairs(1, early);
    checks++;
    if (bus.symbol_done !== 1'b1) begin
      errors++;
      $display("FAIL freeze_done: done=%b want 1", bus.symbol_done);
    end
    cyc();
    checks++;
    if (bus.sym_count !== 16'd2) begin
      errors++;
      $display("FAIL freeze_count: cnt=%0d want 2", bus.sym_count);
    end
  endtask

  initial begin
    bus.enable           = 1'b1;
    bus.rate_in          = 8'd0;
    bus.rate_valid       = 1'b0;
    bus.in_bits          = 6'd0;
    bus.in_strobe        = 1'b0;
    bus.deint_out_strobe = 1'b0;
    test_reset();
    test_legacy();
    test_ht_overrun();
    test_rate_change();
    test_bad_rate();
    test_timeout();
    test_reset_mid();
    test_enable_freeze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
